// File: rtl/rv32_pkg.sv
// Shared definitions for the data-memory path: DmCtrl access encodings and LSU states.
package rv32_pkg;

    localparam logic [2:0] DM_B  = 3'b000;
    localparam logic [2:0] DM_H  = 3'b001;
    localparam logic [2:0] DM_W  = 3'b010;
    localparam logic [2:0] DM_BU = 3'b100;
    localparam logic [2:0] DM_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2,
        ERR   = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane steering for dm_lsu: store strobes/replication, load extraction/extension,
// and the illegal-encoding / misalignment check. Purely combinational.
module dm_lane_align
    import rv32_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  ctrl,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_word,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata_ext,
    output logic        req_err
);

    logic        illegal;
    logic        misaligned;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        illegal    = (ctrl == 3'b011) || (ctrl == 3'b110) || (ctrl == 3'b111) || (we && ctrl[2]);
        misaligned = ((ctrl == DM_H || ctrl == DM_HU) && addr_lo[0]) ||
                     ((ctrl == DM_W) && (addr_lo != 2'b00));
        req_err    = illegal || misaligned;
    end

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata_word[7:0];
            2'd1:    byte_sel = rdata_word[15:8];
            2'd2:    byte_sel = rdata_word[23:16];
            default: byte_sel = rdata_word[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata_word[31:16] : rdata_word[15:0];

        case (ctrl)
            DM_B:    rdata_ext = {{24{byte_sel[7]}}, byte_sel};
            DM_BU:   rdata_ext = {24'd0, byte_sel};
            DM_H:    rdata_ext = {{16{half_sel[15]}}, half_sel};
            DM_HU:   rdata_ext = {16'd0, half_sel};
            default: rdata_ext = rdata_word;
        endcase
    end

    always_comb begin
        wstrb       = 4'b0000;
        wdata_lanes = wdata;
        case (ctrl[1:0])
            2'b00: begin
                wdata_lanes = {4{wdata[7:0]}};
                wstrb       = 4'b0001 << addr_lo;
            end
            2'b01: begin
                wdata_lanes = {2{wdata[15:0]}};
                wstrb       = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                wdata_lanes = wdata;
                wstrb       = 4'b1111;
            end
            default: begin
                wdata_lanes = wdata;
                wstrb       = 4'b0000;
            end
        endcase
        // Loads never drive byte enables.
        if (!we) begin
            wstrb = 4'b0000;
        end
    end

endmodule

// File: rtl/dm_lsu.sv
// Load/store sequencer: one valid/ready bus transaction per start pulse, with timeout,
// returning extended load data or an error through a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start; request checked and latched here
// ISSUE | bus_valid high, waiting for bus_ready or timeout
// DONE  | done=1, err=0 for one cycle
// ERR   | done=1, err=1 for one cycle (illegal, misaligned or timeout)
module dm_lsu
    import rv32_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        DmWr,
    input  logic [2:0]  DmCtrl,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        bus_valid,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned   CW      = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

    lsu_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [2:0]    ctrl_q, ctrl_d;
    logic [1:0]    addr_lo_q, addr_lo_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          bus_valid_q, bus_valid_d;
    logic          bus_we_q, bus_we_d;
    logic [31:0]   bus_addr_q, bus_addr_d;
    logic [3:0]    bus_wstrb_q, bus_wstrb_d;
    logic [31:0]   bus_wdata_q, bus_wdata_d;

    logic          idle;
    logic [2:0]    al_ctrl;
    logic [1:0]    al_addr_lo;
    logic [3:0]    al_wstrb;
    logic [31:0]   al_wdata;
    logic [31:0]   al_rdata;
    logic          al_req_err;

    // In IDLE the aligner checks/formats the incoming request; afterwards it
    // extracts load data using the latched access.
    assign idle       = (state_q == IDLE);
    assign al_ctrl    = idle ? DmCtrl    : ctrl_q;
    assign al_addr_lo = idle ? addr[1:0] : addr_lo_q;

    dm_lane_align u_align (
        .we          (DmWr),
        .ctrl        (al_ctrl),
        .addr_lo     (al_addr_lo),
        .wdata       (wdata),
        .rdata_word  (bus_rdata),
        .wstrb       (al_wstrb),
        .wdata_lanes (al_wdata),
        .rdata_ext   (al_rdata),
        .req_err     (al_req_err)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        ctrl_d      = ctrl_q;
        addr_lo_d   = addr_lo_q;
        rdata_d     = rdata_q;
        bus_valid_d = 1'b0;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wstrb_d = bus_wstrb_q;
        bus_wdata_d = bus_wdata_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    we_d      = DmWr;
                    ctrl_d    = DmCtrl;
                    addr_lo_d = addr[1:0];
                    if (al_req_err) begin
                        state_d = ERR;
                    end else begin
                        state_d     = ISSUE;
                        cnt_d       = '0;
                        bus_valid_d = 1'b1;
                        bus_we_d    = DmWr;
                        bus_addr_d  = {addr[31:2], 2'b00};
                        bus_wstrb_d = al_wstrb;
                        bus_wdata_d = al_wdata;
                    end
                end
            end
            ISSUE: begin
                if (bus_ready) begin
                    state_d = DONE;
                    if (!we_q) begin
                        rdata_d = al_rdata;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ERR;
                end else begin
                    cnt_d       = cnt_q + CW'(1);
                    bus_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE) || (state_d == ERR);
        err_d  = (state_d == ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            ctrl_q      <= 3'b000;
            addr_lo_q   <= 2'b00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            bus_valid_q <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wstrb_q <= '0;
            bus_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            ctrl_q      <= ctrl_d;
            addr_lo_q   <= addr_lo_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            bus_valid_q <= bus_valid_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wstrb_q <= bus_wstrb_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign bus_valid = bus_valid_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wstrb = bus_wstrb_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_dm_lsu.sv
// Directed self-checking bench for dm_lsu: loads, stores, wait states, errors, timeout, reset.
module tb_dm_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        DmWr;
    logic [2:0]  DmCtrl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    int n_checks = 0;
    int n_fails  = 0;
    int vcount;

    dm_lsu #(.TIMEOUT_CYCLES(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .DmWr      (DmWr),
        .DmCtrl    (DmCtrl),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .bus_valid (bus_valid),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wstrb (bus_wstrb),
        .bus_wdata (bus_wdata),
        .bus_ready (bus_ready),
        .bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents a request for one cycle; on return the bench is in cycle N+1.
    task automatic req(input logic we, input logic [2:0] ctrl, input logic [31:0] a,
                       input logic [31:0] wd);
        start  = 1'b1;
        DmWr   = we;
        DmCtrl = ctrl;
        addr   = a;
        wdata  = wd;
        tick();
        start  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; DmWr = 1'b0; DmCtrl = 3'b000;
        addr = '0; wdata = '0; bus_ready = 1'b0; bus_rdata = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_busy",  busy,      0);
        chk("rst_done",  done,      0);
        chk("rst_valid", bus_valid, 0);
        chk("rst_rdata", rdata,     0);
        chk("rst_wstrb", bus_wstrb, 0);
        chk("rst_addr",  bus_addr,  0);

        // LW zero-wait
        bus_ready = 1'b1; bus_rdata = 32'hDEADBEEF;
        req(1'b0, 3'b010, 32'h100, 32'h0);
        chk("lw_valid", bus_valid, 1);
        chk("lw_addr",  bus_addr,  32'h100);
        chk("lw_wstrb", bus_wstrb, 4'b0000);
        chk("lw_we",    bus_we,    0);
        chk("lw_busy",  busy,      1);
        chk("lw_done0", done,      0);
        tick();
        chk("lw_done",  done,      1);
        chk("lw_err",   err,       0);
        chk("lw_rdata", rdata,     32'hDEADBEEF);
        chk("lw_vdrop", bus_valid, 0);
        tick();
        chk("lw_pulse", done,      0);
        chk("lw_idle",  busy,      0);

        // Byte/half loads from a fixed word
        bus_rdata = 32'h80123456;
        req(1'b0, 3'b000, 32'h103, 32'h0); tick();
        chk("lb_rdata", rdata, 32'hFFFFFF80);
        tick();
        req(1'b0, 3'b101, 32'h100, 32'h0); tick();
        chk("lhu_rdata", rdata, 32'h00003456);
        tick();
        req(1'b0, 3'b001, 32'h102, 32'h0); tick();
        chk("lh_rdata", rdata, 32'hFFFF8012);
        tick();
        req(1'b0, 3'b100, 32'h103, 32'h0); tick();
        chk("lbu_rdata", rdata, 32'h00000080);
        tick();

        // SH upper half with 3 wait cycles and a stray start while busy
        bus_ready = 1'b0;
        req(1'b1, 3'b001, 32'h22, 32'h0000ABCD);
        for (int i = 0; i < 4; i++) begin
            chk("sh_valid", bus_valid, 1);
            chk("sh_we",    bus_we,    1);
            chk("sh_addr",  bus_addr,  32'h20);
            chk("sh_wstrb", bus_wstrb, 4'b1100);
            chk("sh_wdata", bus_wdata, 32'hABCDABCD);
            chk("sh_done0", done,      0);
            start = (i == 1);
            if (i == 1) begin
                DmWr = 1'b0; DmCtrl = 3'b010; addr = 32'h300;
            end
            if (i == 3) bus_ready = 1'b1;
            tick();
        end
        start = 1'b0;
        chk("sh_done",  done,  1);
        chk("sh_err",   err,   0);
        chk("sh_rdata", rdata, 32'h00000080);
        tick();
        chk("sh_idle",    busy,      0);
        chk("sh_nostray", bus_valid, 0);
        tick();
        chk("sh_nostray2", bus_valid, 0);

        // SB lane 1 and SW
        req(1'b1, 3'b000, 32'h01, 32'h12345677);
        chk("sb_wstrb", bus_wstrb, 4'b0010);
        chk("sb_wdata", bus_wdata, 32'h77777777);
        chk("sb_addr",  bus_addr,  32'h0);
        tick(); tick();
        req(1'b1, 3'b010, 32'h04, 32'hCAFEF00D);
        chk("sw_wstrb", bus_wstrb, 4'b1111);
        chk("sw_wdata", bus_wdata, 32'hCAFEF00D);
        tick(); tick();

        // Misaligned and illegal requests
        req(1'b0, 3'b010, 32'h102, 32'h0);
        chk("mis_done",  done,      1);
        chk("mis_err",   err,       1);
        chk("mis_valid", bus_valid, 0);
        chk("mis_busy",  busy,      1);
        tick();
        chk("mis_pulse", done,      0);
        chk("mis_idle",  busy,      0);
        chk("mis_novalid", bus_valid, 0);
        req(1'b1, 3'b100, 32'h100, 32'h0);
        chk("ill_st_done",  done,      1);
        chk("ill_st_err",   err,       1);
        chk("ill_st_valid", bus_valid, 0);
        tick();
        req(1'b0, 3'b011, 32'h100, 32'h0);
        chk("ill_ld_err", err, 1);
        tick();
        req(1'b0, 3'b001, 32'h101, 32'h0);
        chk("mis_h_err", err, 1);
        tick();
        chk("err_rdata", rdata, 32'h00000080);

        // Timeout
        bus_ready = 1'b0;
        vcount = 0;
        req(1'b0, 3'b010, 32'h200, 32'h0);
        for (int i = 0; i < 16; i++) begin
            if (bus_valid) vcount++;
            tick();
        end
        chk("to_vcount", vcount,    16);
        chk("to_done",   done,      1);
        chk("to_err",    err,       1);
        chk("to_valid",  bus_valid, 0);
        chk("to_rdata",  rdata,     32'h00000080);
        tick();
        chk("to_idle",   busy,      0);

        // Reset during ISSUE
        req(1'b0, 3'b010, 32'h40, 32'h0);
        chk("rsti_valid", bus_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rsti_valid0", bus_valid, 0);
        chk("rsti_busy",   busy,      0);
        chk("rsti_done",   done,      0);
        bus_ready = 1'b1;
        tick();
        chk("rsti_nodone", done,      0);
        chk("rsti_rdata",  rdata,     0);

        // Reset and start together: reset wins
        rst = 1'b1;
        req(1'b0, 3'b010, 32'h40, 32'h0);
        rst = 1'b0;
        chk("rs_busy",  busy,      0);
        chk("rs_valid", bus_valid, 0);
        tick();
        chk("rs_done",  done,      0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
